// File: rtl/vote_result_reader.sv
// Snapshots four candidate vote counts on start and streams them over valid/ready,
// publishing winner/tie when the readout completes. Define VOTE_TOTAL_EN for a 5th total beat.
module vote_result_reader #(
  parameter int CNT_W  = 8,
  parameter int DATA_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mode,
  input  logic              start,
  input  logic [CNT_W-1:0]  candi1_count,
  input  logic [CNT_W-1:0]  candi2_count,
  input  logic [CNT_W-1:0]  candi3_count,
  input  logic [CNT_W-1:0]  candi4_count,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [2:0]        rd_id,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              result_done,
  output logic [1:0]        winner_id,
  output logic [CNT_W-1:0]  winner_count,
  output logic              tie
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

`ifdef VOTE_TOTAL_EN
  localparam logic [2:0] LAST_BEAT = 3'd4;
`else
  localparam logic [2:0] LAST_BEAT = 3'd3;
`endif

  state_t             state, next_state;
  logic [CNT_W-1:0]   snap [4];
  logic [2:0]         beat;
  logic [CNT_W-1:0]   max_r, nxt_max;
  logic [1:0]         id_r, nxt_id;
  logic               tie_r, nxt_tie;
  logic [CNT_W-1:0]   cur_cnt;
  logic               accept;
  logic               last_beat;

  assign cur_cnt   = snap[beat[1:0]];
  assign last_beat = (beat == LAST_BEAT);
  assign accept    = (state == SEND) && rd_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start && mode) next_state = SEND;
      SEND: begin
        if (!mode)                     next_state = IDLE;
        else if (accept && last_beat)  next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Running winner including the beat currently on the bus; the total beat leaves it untouched
  always_comb begin
    nxt_max = max_r;
    nxt_id  = id_r;
    nxt_tie = tie_r;
    if (beat == 3'd0) begin
      nxt_max = cur_cnt;
      nxt_id  = 2'd0;
      nxt_tie = 1'b0;
    end else if (beat < 3'd4) begin
      if (cur_cnt > max_r) begin
        nxt_max = cur_cnt;
        nxt_id  = beat[1:0];
        nxt_tie = 1'b0;
      end else if (cur_cnt == max_r) begin
        nxt_tie = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) snap[i] <= '0;
      beat         <= '0;
      max_r        <= '0;
      id_r         <= '0;
      tie_r        <= 1'b0;
      winner_id    <= '0;
      winner_count <= '0;
      tie          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && mode) begin
            snap[0] <= candi1_count;
            snap[1] <= candi2_count;
            snap[2] <= candi3_count;
            snap[3] <= candi4_count;
            beat    <= '0;
          end
        end
        SEND: begin
          if (!mode) begin
            beat <= '0;
          end else if (accept) begin
            max_r <= nxt_max;
            id_r  <= nxt_id;
            tie_r <= nxt_tie;
            if (last_beat) begin
              winner_id    <= nxt_id;
              winner_count <= nxt_max;
              tie          <= nxt_tie;
            end else begin
              beat <= beat + 3'd1;
            end
          end
        end
        DONE:    beat <= '0;
        default: beat <= '0;
      endcase
    end
  end

  assign rd_valid    = (state == SEND);
  assign busy        = (state == SEND);
  assign result_done = (state == DONE);
  assign rd_id       = beat;
  assign rd_last     = (state == SEND) && last_beat;

`ifdef VOTE_TOTAL_EN
  always_comb begin
    if (beat == 3'd4)
      rd_data = DATA_W'(snap[0]) + DATA_W'(snap[1]) + DATA_W'(snap[2]) + DATA_W'(snap[3]);
    else
      rd_data = DATA_W'(cur_cnt);
  end
`else
  assign rd_data = DATA_W'(cur_cnt);
`endif

endmodule

// File: tb/tb_vote_result_reader.sv
// Directed self-checking bench for vote_result_reader using immediate assertions.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_vote_result_reader;

`ifdef VOTE_TOTAL_EN
  localparam int NBEATS = 5;
`else
  localparam int NBEATS = 4;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       mode;
  logic       start;
  logic [7:0] candi1_count, candi2_count, candi3_count, candi4_count;
  logic       rd_valid;
  logic       rd_ready;
  logic [2:0] rd_id;
  logic [9:0] rd_data;
  logic       rd_last;
  logic       busy;
  logic       result_done;
  logic [1:0] winner_id;
  logic [7:0] winner_count;
  logic       tie;

  int n_assert = 0;
  int n_fail   = 0;

  vote_result_reader #(.CNT_W(8), .DATA_W(10)) dut (
    .clock(clock), .reset(reset), .mode(mode), .start(start),
    .candi1_count(candi1_count), .candi2_count(candi2_count),
    .candi3_count(candi3_count), .candi4_count(candi4_count),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_id(rd_id), .rd_data(rd_data),
    .rd_last(rd_last), .busy(busy), .result_done(result_done),
    .winner_id(winner_id), .winner_count(winner_count), .tie(tie)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input int id, input int data, input bit last);
    check_output({tag, " valid"}, 32'(rd_valid), 32'd1);
    check_output({tag, " id"},    32'(rd_id),    32'(id));
    check_output({tag, " data"},  32'(rd_data),  32'(data));
    check_output({tag, " last"},  32'(rd_last),  32'(last));
  endtask

  task automatic check_winner(input string tag, input int wid, input int wcnt, input bit wtie);
    check_output({tag, " winner_id"},    32'(winner_id),    32'(wid));
    check_output({tag, " winner_count"}, 32'(winner_count), 32'(wcnt));
    check_output({tag, " tie"},          32'(tie),          32'(wtie));
  endtask

  task automatic apply_stimulus(input int c1, input int c2, input int c3, input int c4);
    candi1_count = 8'(c1);
    candi2_count = 8'(c2);
    candi3_count = 8'(c3);
    candi4_count = 8'(c4);
    mode  = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Full readout with rd_ready held high; total is the hand-computed sum for the 5th beat
  task automatic do_readout(input string tag, input int c1, input int c2, input int c3,
                            input int c4, input int total, input int wid, input int wcnt,
                            input bit wtie);
    int exp_data [5];
    exp_data = '{c1, c2, c3, c4, total};
    rd_ready = 1'b1;
    apply_stimulus(c1, c2, c3, c4);
    for (int i = 0; i < NBEATS; i++) begin
      check_beat($sformatf("%s beat%0d", tag, i), i, exp_data[i], i == NBEATS - 1);
      @(negedge clock);
    end
    check_output({tag, " done pulse"}, 32'(result_done), 32'd1);
    check_output({tag, " done valid"}, 32'(rd_valid),    32'd0);
    check_winner(tag, wid, wcnt, wtie);
    @(negedge clock);
    check_output({tag, " done drop"}, 32'(result_done), 32'd0);
    check_output({tag, " idle busy"}, 32'(busy),        32'd0);
  endtask

  initial begin
    reset = 1'b0;
    mode = 1'b0;
    start = 1'b0;
    rd_ready = 1'b0;
    candi1_count = '0; candi2_count = '0; candi3_count = '0; candi4_count = '0;
    #1;
    check_output("reset valid", 32'(rd_valid),    32'd0);
    check_output("reset busy",  32'(busy),        32'd0);
    check_output("reset done",  32'(result_done), 32'd0);
    check_output("reset last",  32'(rd_last),     32'd0);
    check_winner("reset", 0, 0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Start in voting mode is ignored
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check_output("vote mode ignored", 32'(rd_valid), 32'd0);

    do_readout("t1", 5, 9, 3, 1, 18, 1, 9, 1'b0);

    // Backpressure on beat 1
    rd_ready = 1'b1;
    apply_stimulus(5, 9, 3, 1);
    check_beat("t2 beat0", 0, 5, 1'b0);
    @(negedge clock);
    check_beat("t2 beat1", 1, 9, 1'b0);
    rd_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check_beat($sformatf("t2 hold%0d", k), 1, 9, 1'b0);
    end
    rd_ready = 1'b1;
    @(negedge clock);
    check_beat("t2 beat2", 2, 3, 1'b0);
    @(negedge clock);
    check_beat("t2 beat3", 3, 1, NBEATS == 4);
    @(negedge clock);
`ifdef VOTE_TOTAL_EN
    check_beat("t2 beat4", 4, 18, 1'b1);
    @(negedge clock);
`endif
    check_output("t2 done", 32'(result_done), 32'd1);
    check_winner("t2", 1, 9, 1'b0);
    @(negedge clock);

    do_readout("t3a", 7, 2, 7, 0, 16, 0, 7, 1'b1);
    do_readout("t3b", 4, 4, 9, 0, 17, 2, 9, 1'b0);
    do_readout("t3c", 0, 0, 0, 0, 0, 0, 0, 1'b1);
    do_readout("t3d", 3, 8, 2, 8, 21, 1, 8, 1'b1);

    // Live changes and a repeated start during the readout are ignored
    rd_ready = 1'b1;
    apply_stimulus(5, 9, 3, 1);
    candi3_count = 8'd50;
    check_beat("t4 beat0", 0, 5, 1'b0);
    @(negedge clock);
    check_beat("t4 beat1", 1, 9, 1'b0);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check_beat("t4 beat2", 2, 3, 1'b0);
    @(negedge clock);
    check_beat("t4 beat3", 3, 1, NBEATS == 4);
    @(negedge clock);
`ifdef VOTE_TOTAL_EN
    check_beat("t4 beat4", 4, 18, 1'b1);
    @(negedge clock);
`endif
    check_output("t4 done", 32'(result_done), 32'd1);
    check_winner("t4", 1, 9, 1'b0);
    @(negedge clock);
    check_output("t4 no restart", 32'(rd_valid), 32'd0);
    @(negedge clock);

    // Abort by dropping mode while beat 1 is pending
    rd_ready = 1'b1;
    apply_stimulus(1, 2, 3, 8);
    check_beat("t5 beat0", 0, 1, 1'b0);
    @(negedge clock);
    check_beat("t5 beat1", 1, 2, 1'b0);
    rd_ready = 1'b0;
    mode = 1'b0;
    @(negedge clock);
    check_output("t5 abort valid", 32'(rd_valid),    32'd0);
    check_output("t5 abort busy",  32'(busy),        32'd0);
    check_output("t5 abort done",  32'(result_done), 32'd0);
    check_winner("t5 abort", 1, 9, 1'b0);
    @(negedge clock);
    check_output("t5 abort done2", 32'(result_done), 32'd0);
    check_winner("t5 abort2", 1, 9, 1'b0);

    // Asynchronous reset in the middle of a readout
    rd_ready = 1'b0;
    apply_stimulus(1, 2, 3, 8);
    @(negedge clock);
    check_beat("t5 pre-reset", 0, 1, 1'b0);
    reset = 1'b0;
    #1;
    check_output("t5 rst valid", 32'(rd_valid), 32'd0);
    check_output("t5 rst busy",  32'(busy),     32'd0);
    check_output("t5 rst id",    32'(rd_id),    32'd0);
    check_output("t5 rst data",  32'(rd_data),  32'd0);
    check_winner("t5 rst", 0, 0, 1'b0);
    #1;
    reset = 1'b1;
    @(negedge clock);
    check_output("t5 post-reset valid", 32'(rd_valid), 32'd0);

`ifdef VOTE_TOTAL_EN
    do_readout("t6", 255, 255, 255, 255, 1020, 0, 255, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
